hl_west_io_ctrl: RTL and testbench
==================================

// Module: hl_west_io_ctrl
// PURPOSE
// Sequencer and configuration controller for the 4-slice west I/O pad bank. Holds pads safe through power-up,
// then applies per-slice config (direction, pulls, drive, slew) from a valid/ready port. Uses break-before-make
// dead time on every config change. Registers TX data into the pads; synchronises pad input data back to core.
// Sits between core/TileLink-side config registers and the west I/O wrapper (true-polarity dq).
// PARAMETERS
// PWRUP_CYCLES  64  cycles pads held in power-up state after reset release (>=1)
// DEAD_CYCLES   4   cycles a slice's driver is off before new config applied (>=1)
// PORTS
// clock          in   1   core clock
// reset          in   1   asynchronous active-high reset
// cfg_valid      in   1   config request
// cfg_ready      out  1   controller accepts request when high (IDLE only)
// cfg_slice      in   2   target slice 0..3
// cfg_data       in   9   [0]oe [1]ie [2]pu [3]pd [6:4]drv[2:0] [7]slew [8]ppen
// cfg_err        out  1   sticky: a request had pu&pd both set; cleared by reset only
// pwrup_done     out  1   high once power-up sequence complete
// tx_data        in   4   per-slice output data
// rx_data        out  4   synchronised pad input data
// dq,enq,enabq,puq,pd,drv0,drv1,drv2,prg_slew,ppen  out 4 each  per-slice pad controls (bit i = slice i)
// pwrup_pull_en,pwrupzhl  out 4 each  pad power-up controls
// outi           in   4   raw pad input from wrapper
// BEHAVIOUR
// - Reset values: cfg_ready=0 cfg_err=0 pwrup_done=0 rx_data=0 dq=0 enq=4'hF enabq=4'hF puq=4'hF pd=0
//   drv0/1/2=0 prg_slew=0 ppen=0 pwrup_pull_en=4'hF pwrupzhl=0. All outputs registered.
// - enq/enabq/puq active-low (0 = output drive / input buffer / pull-up on); pd, ppen, drv*, prg_slew active-high.
// - FSM: PWRUP -> RELEASE -> IDLE -> OFF -> APPLY -> IDLE.
//   PWRUP: counter 0..PWRUP_CYCLES-1, outputs at reset values; on terminal count -> RELEASE.
//   RELEASE (1 cycle): pwrupzhl<=4'hF, pwrup_pull_en<=0, pwrup_done<=1 -> IDLE.
//   IDLE: cfg_ready=1; cfg_valid&cfg_ready latches slice/data -> OFF.
//   OFF: enq[slice]<=1 on entry; hold DEAD_CYCLES cycles (counter reloaded on entry).
//   APPLY (1 cycle): write puq,pd,drv*,prg_slew,ppen,enabq[slice]=~ie, then enq[slice]=~oe; -> IDLE.
// - Request-to-new-config latency: DEAD_CYCLES+2 cycles; cfg_ready low from acceptance until back in IDLE.
// - pu&pd both set: request still executed with pu forced off (puq[slice]=1), cfg_err<=1.
// - Other slices' controls never change during a sequence; same-slice repeat config re-runs OFF/APPLY.
// - dq[i] <= tx_data[i] every cycle when enq[i]==0; holds last value when driver off.
// - rx_data: 2-flop sync of outi, gated: rx_data[i]=0 while enabq[i]=1.
// - cfg_valid before pwrup_done ignored (cfg_ready=0); requester holds it until accepted.
// - Reset mid-sequence: all state and outputs return to reset values asynchronously; PWRUP restarts.
// - Counter widths: $clog2(param)+1 bits; no wrap, counters saturate at terminal count.
// CONFIGURATION
// - WEST_IO_RX_FILTER_EN defined: 3-sample majority filter after the 2-flop sync.
//   rx_data latency 3 cycles; single-cycle glitches on outi suppressed.
// - Not defined: 2-flop sync only, rx_data latency 2 cycles, no filtering.
// TESTING
// - Reset release, PWRUP_CYCLES=64 -> pwrup_done=1, pwrupzhl=4'hF, pwrup_pull_en=0 at cycle 65; enq=4'hF until then.
// - Slice2 cfg_data=9'h013 (oe,ie,drv=1) -> enq[2]=1 for 4 cycles, then enq[2]=0 drv0[2]=1 enabq[2]=0 at +6.
// - Reconfig slice2 oe=1->0 with tx_data=4'hF -> dq[2] holds 1; enq[2] goes 1 first, no other slice bits toggle.
// - cfg_data=9'h00C (pu&pd) slice0 -> cfg_err=1, puq[0]=1, pd[0]=1; cfg_err persists through later requests.
// - outi[1] single-cycle pulse with ie=1 -> seen on rx_data[1] after 2 cycles without macro; absent with macro.
// - reset asserted in OFF state -> all outputs at reset values same cycle (async); PWRUP re-runs full 64 cycles.

Source files
------------

// File: rtl/hl_west_io_ctrl.sv
// hl_west_io_ctrl: power-up sequencer and per-slice configuration controller
// for the 4-slice west I/O pad bank.
//
// State | meaning
// ------+-------------------------------------------------------------
// PWRUP   | pads held in the safe power-up state while the timer runs
// RELEASE | one cycle: drop the power-up pulls and release pwrupzhl
// IDLE    | cfg_ready high; waiting for a config request
// OFF     | dead time: the target slice's driver is off while the timer runs
// APPLY   | one cycle: write the new slice config, then re-enable its driver
//
// Build option: define WEST_IO_RX_FILTER_EN to add a 3-sample majority filter
// on the receive path. The filter raises rx_data latency from 2 to 3 cycles and
// suppresses single-cycle glitches. Without it the receive path is a 2-flop
// synchroniser only.
module hl_west_io_ctrl #(
    parameter int PWRUP_CYCLES = 64,
    parameter int DEAD_CYCLES  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_slice,
    input  logic [8:0] cfg_data,
    output logic       cfg_err,
    output logic       pwrup_done,
    input  logic [3:0] tx_data,
    output logic [3:0] rx_data,
    output logic [3:0] dq,
    output logic [3:0] enq,
    output logic [3:0] enabq,
    output logic [3:0] puq,
    output logic [3:0] pd,
    output logic [3:0] drv0,
    output logic [3:0] drv1,
    output logic [3:0] drv2,
    output logic [3:0] prg_slew,
    output logic [3:0] ppen,
    output logic [3:0] pwrup_pull_en,
    output logic [3:0] pwrupzhl,
    input  logic [3:0] outi
);

    localparam int PW = $clog2(PWRUP_CYCLES) + 1;
    localparam int DW = $clog2(DEAD_CYCLES) + 1;

    typedef enum logic [2:0] {
        ST_PWRUP   = 3'd0,
        ST_RELEASE = 3'd1,
        ST_IDLE    = 3'd2,
        ST_OFF     = 3'd3,
        ST_APPLY   = 3'd4
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [PW-1:0]  pwr_cnt;
    logic [DW-1:0]  dead_cnt;
    logic [1:0]     sel_slice;
    logic [8:0]     sel_data;
    logic           accept;
    logic [3:0]     rx_s1;
    logic [3:0]     rx_val;

    assign accept = (state == ST_IDLE) && cfg_valid && cfg_ready;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_PWRUP;
        else       state <= state_next;
    end

    // Next-state logic; both timers count down to zero and stop there
    always_comb begin
        state_next = state;
        case (state)
            ST_PWRUP:   if (pwr_cnt == '0) state_next = ST_RELEASE;
            ST_RELEASE: state_next = ST_IDLE;
            ST_IDLE:    if (accept) state_next = ST_OFF;
            ST_OFF:     if (dead_cnt == '0) state_next = ST_APPLY;
            ST_APPLY:   state_next = ST_IDLE;
            default:    state_next = ST_PWRUP;
        endcase
    end

    // Power-up and dead-time timers, plus capture of the accepted request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwr_cnt   <= PW'(PWRUP_CYCLES - 1);
            dead_cnt  <= '0;
            sel_slice <= '0;
            sel_data  <= '0;
        end else begin
            if (state == ST_PWRUP && pwr_cnt != '0) pwr_cnt <= pwr_cnt - 1'b1;
            if (accept) begin
                dead_cnt  <= DW'(DEAD_CYCLES - 1);
                sel_slice <= cfg_slice;
                sel_data  <= cfg_data;
            end else if (state == ST_OFF && dead_cnt != '0) begin
                dead_cnt <= dead_cnt - 1'b1;
            end
        end
    end

    // Pad control outputs; only the selected slice's bits are ever written
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_ready     <= 1'b0;
            cfg_err       <= 1'b0;
            pwrup_done    <= 1'b0;
            enq           <= 4'hF;
            enabq         <= 4'hF;
            puq           <= 4'hF;
            pd            <= 4'h0;
            drv0          <= 4'h0;
            drv1          <= 4'h0;
            drv2          <= 4'h0;
            prg_slew      <= 4'h0;
            ppen          <= 4'h0;
            pwrup_pull_en <= 4'hF;
            pwrupzhl      <= 4'h0;
        end else begin
            cfg_ready <= (state_next == ST_IDLE);
            if (state == ST_RELEASE) begin
                pwrupzhl      <= 4'hF;
                pwrup_pull_en <= 4'h0;
                pwrup_done    <= 1'b1;
            end
            if (accept) begin
                enq[cfg_slice] <= 1'b1;
                if (cfg_data[2] && cfg_data[3]) cfg_err <= 1'b1;
            end
            if (state == ST_APPLY) begin
                // A pull-up that conflicts with the pull-down is dropped
                puq[sel_slice]      <= ~(sel_data[2] & ~sel_data[3]);
                pd[sel_slice]       <= sel_data[3];
                drv0[sel_slice]     <= sel_data[4];
                drv1[sel_slice]     <= sel_data[5];
                drv2[sel_slice]     <= sel_data[6];
                prg_slew[sel_slice] <= sel_data[7];
                ppen[sel_slice]     <= sel_data[8];
                enabq[sel_slice]    <= ~sel_data[1];
                enq[sel_slice]      <= ~sel_data[0];
            end
        end
    end

    // TX data follows tx_data only on slices whose driver is enabled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dq <= 4'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!enq[i]) dq[i] <= tx_data[i];
            end
        end
    end

`ifdef WEST_IO_RX_FILTER_EN
    logic [3:0] rx_s2;
    logic [3:0] rx_s3;

    // Synchroniser chain with history taps feeding the majority vote
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_s1 <= 4'h0;
            rx_s2 <= 4'h0;
            rx_s3 <= 4'h0;
        end else begin
            rx_s1 <= outi;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_val = (rx_s1 & rx_s2) | (rx_s2 & rx_s3) | (rx_s1 & rx_s3);
`else
    // First synchroniser stage; rx_data is the second
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rx_s1 <= 4'h0;
        else       rx_s1 <= outi;
    end

    assign rx_val = rx_s1;
`endif

    // Final receive register, forced low on slices whose input buffer is off
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rx_data <= 4'h0;
        else       rx_data <= rx_val & ~enabq;
    end

endmodule

// File: tb/tb_hl_west_io_ctrl.sv
// Directed self-checking bench for hl_west_io_ctrl (default parameters).
module tb_hl_west_io_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_slice = 2'd0;
    logic [8:0] cfg_data = 9'h000;
    logic       cfg_err;
    logic       pwrup_done;
    logic [3:0] tx_data = 4'h0;
    logic [3:0] rx_data;
    logic [3:0] dq, enq, enabq, puq, pd, drv0, drv1, drv2, prg_slew, ppen;
    logic [3:0] pwrup_pull_en, pwrupzhl;
    logic [3:0] outi = 4'h0;

    int checks = 0;
    int errors = 0;

    hl_west_io_ctrl dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_slice(cfg_slice), .cfg_data(cfg_data),
        .cfg_err(cfg_err), .pwrup_done(pwrup_done),
        .tx_data(tx_data), .rx_data(rx_data),
        .dq(dq), .enq(enq), .enabq(enabq), .puq(puq), .pd(pd),
        .drv0(drv0), .drv1(drv1), .drv2(drv2),
        .prg_slew(prg_slew), .ppen(ppen),
        .pwrup_pull_en(pwrup_pull_en), .pwrupzhl(pwrupzhl),
        .outi(outi)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    // Request presented now, accepted on the next edge, new config 6 edges later
    task automatic do_cfg(input logic [1:0] s, input logic [8:0] d);
        cfg_valid = 1'b1;
        cfg_slice = s;
        cfg_data  = d;
        tick(1);
        cfg_valid = 1'b0;
        tick(5);
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_enq", enq, 4'hF);
        check("rst_enabq", enabq, 4'hF);
        check("rst_puq", puq, 4'hF);
        check("rst_pull_en", pwrup_pull_en, 4'hF);
        check("rst_pwrupzhl", pwrupzhl, 4'h0);
        check("rst_pwrup_done", pwrup_done, 0);

        // Power-up; a request during power-up must be ignored
        reset = 1'b0;
        cfg_valid = 1'b1;
        cfg_slice = 2'd3;
        cfg_data  = 9'h001;
        tick(64);
        check("pu64_done", pwrup_done, 0);
        check("pu64_enq", enq, 4'hF);
        check("pu64_ready", cfg_ready, 0);
        check("pu64_zhl", pwrupzhl, 4'h0);
        tick(1);
        cfg_valid = 1'b0;
        check("pu65_done", pwrup_done, 1);
        check("pu65_zhl", pwrupzhl, 4'hF);
        check("pu65_pull_en", pwrup_pull_en, 4'h0);
        check("pu65_ready", cfg_ready, 1);
        check("pu65_enq", enq, 4'hF);

        // Slice 2: oe, ie, drv=1
        cfg_valid = 1'b1;
        cfg_slice = 2'd2;
        cfg_data  = 9'h013;
        tick(1);
        cfg_valid = 1'b0;
        check("s2_acc_ready", cfg_ready, 0);
        check("s2_acc_enq", enq, 4'hF);
        tick(4);
        check("s2_p5_enq", enq, 4'hF);
        check("s2_p5_drv0", drv0, 4'h0);
        tick(1);
        check("s2_p6_enq", enq, 4'hB);
        check("s2_p6_enabq", enabq, 4'hB);
        check("s2_p6_drv0", drv0, 4'h4);
        check("s2_p6_puq", puq, 4'hF);
        check("s2_p6_ready", cfg_ready, 1);
        tx_data = 4'hF;
        tick(1);
        check("s2_dq", dq, 4'h4);

        // RX sync latency and gating by enabq
        outi = 4'b0110;
        tick(1);
        check("rx_lat1", rx_data, 4'h0);
        tick(1);
        check("rx_lat2", rx_data, 4'h4);
        outi = 4'h0;
        tick(2);
        check("rx_clear", rx_data, 4'h0);

        // Slice 1: input buffer only, other slices untouched
        do_cfg(2'd1, 9'h002);
        check("s1_enq", enq, 4'hB);
        check("s1_enabq", enabq, 4'h9);
        check("s1_drv0", drv0, 4'h4);

        // Single-cycle glitch on outi[1]
        outi = 4'b0010;
        tick(1);
        outi = 4'h0;
        tick(1);
`ifdef WEST_IO_RX_FILTER_EN
        check("glitch_e2", rx_data, 4'h0);
        tick(1);
        check("glitch_e3", rx_data, 4'h0);
`else
        check("glitch_e2", rx_data, 4'h2);
        tick(1);
        check("glitch_e3", rx_data, 4'h0);
`endif

        // Slice 2 reconfig oe=0; dq must hold its last driven value
        cfg_valid = 1'b1;
        cfg_slice = 2'd2;
        cfg_data  = 9'h012;
        tick(1);
        cfg_valid = 1'b0;
        check("re_acc_enq", enq, 4'hF);
        check("re_acc_dq", dq, 4'h4);
        tick(5);
        check("re_enq", enq, 4'hF);
        check("re_dq", dq, 4'h4);
        check("re_enabq", enabq, 4'h9);
        check("re_drv0", drv0, 4'h4);

        // pu & pd conflict on slice 0
        do_cfg(2'd0, 9'h00C);
        check("pp_err", cfg_err, 1);
        check("pp_puq", puq, 4'hF);
        check("pp_pd", pd, 4'h1);
        do_cfg(2'd3, 9'h004);
        check("pp_err_sticky", cfg_err, 1);
        check("s3_puq", puq, 4'h7);
        check("s3_pd", pd, 4'h1);

        // Reset in the middle of the dead time
        cfg_valid = 1'b1;
        cfg_slice = 2'd3;
        cfg_data  = 9'h1F1;
        tick(1);
        cfg_valid = 1'b0;
        tick(2);
        check("mid_enq", enq, 4'hF);
        reset = 1'b1;
        #1;
        check("ar_enq", enq, 4'hF);
        check("ar_puq", puq, 4'hF);
        check("ar_pd", pd, 4'h0);
        check("ar_err", cfg_err, 0);
        check("ar_done", pwrup_done, 0);
        check("ar_zhl", pwrupzhl, 4'h0);
        check("ar_pull_en", pwrup_pull_en, 4'hF);
        check("ar_ready", cfg_ready, 0);
        check("ar_dq", dq, 4'h0);
        check("ar_enabq", enabq, 4'hF);
        @(negedge clock);
        reset = 1'b0;
        tick(64);
        check("rpu64_done", pwrup_done, 0);
        check("rpu64_drv0", drv0, 4'h0);
        tick(1);
        check("rpu65_done", pwrup_done, 1);
        check("rpu65_zhl", pwrupzhl, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
